clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_ctrl_pkg.sv | 22 ++
 rtl/counter_modulo.sv | 41 ++++
 rtl/clock_set_ctrl.sv | 109 ++++++++++
 tb/tb_clock_set_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared types and limits for the settable time-of-day clock.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_t;

    localparam logic [5:0] SEC_MAX   = 6'd59;
    localparam logic [5:0] MIN_MAX   = 6'd59;
    localparam logic [4:0] HOURS_MAX = 5'd23;

    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v >= SEC_MAX) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_mod24(input logic [4:0] v);
        return (v >= HOURS_MAX) ? 5'd0 : v + 5'd1;
    endfunction

endpackage

// File: rtl/counter_modulo.sv
// Modulo-N counter with a registered tick aligned to the cycle the count is N-1.
module counter_modulo #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;

    // Next count with wrap at N-1.
    always_comb begin
        count_next_s = count_r;
        if (count_r == LAST) begin
            count_next_s = '0;
        end else begin
            count_next_s = count_r + W'(1);
        end
    end

    // Tick is registered together with the count it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            tick    <= 1'b0;
        end else if (en) begin
            count_r <= count_next_s;
            tick    <= (count_next_s == LAST);
        end else begin
            count_r <= count_r;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day clock with a three-state mode FSM for setting hours and minutes.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       blink
);

    localparam int BW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(TICKS_PER_SEC / 2);

    mode_t         mode_r;
    mode_t         mode_next_s;
    logic [BW-1:0] blink_cnt_r;
    logic [BW-1:0] blink_cnt_next_s;
    logic          blink_next_s;
    logic          presc_rst_s;

    // Prescaler is held cleared whenever the clock is being set.
    assign presc_rst_s = reset | (mode_r != MODE_RUN);

    counter_modulo #(
        .N (TICKS_PER_SEC)
    ) u_prescaler (
        .clk  (clk),
        .rst  (presc_rst_s),
        .en   (mode_r == MODE_RUN),
        .tick (sec_tick)
    );

    assign mode = mode_r;

    // Mode sequencing, blink counter and registered blink value.
    always_comb begin
        mode_next_s      = mode_r;
        blink_cnt_next_s = blink_cnt_r;
        case (mode_r)
            MODE_RUN:     mode_next_s = btn_mode ? MODE_SET_HR  : MODE_RUN;
            MODE_SET_HR:  mode_next_s = btn_mode ? MODE_SET_MIN : MODE_SET_HR;
            MODE_SET_MIN: mode_next_s = btn_mode ? MODE_RUN     : MODE_SET_MIN;
            default:      mode_next_s = MODE_RUN;
        endcase
        // The blink phase restarts from zero on every entry into the set states.
        if ((mode_r == MODE_RUN) || (mode_next_s == MODE_RUN)) begin
            blink_cnt_next_s = '0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_next_s = '0;
        end else begin
            blink_cnt_next_s = blink_cnt_r + BW'(1);
        end
        blink_next_s = (mode_next_s == MODE_RUN) || (blink_cnt_next_s < BLINK_HALF);
    end

    // FSM state and time-of-day registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r      <= MODE_RUN;
            hours       <= 5'd0;
            minutes     <= 6'd0;
            seconds     <= 6'd0;
            blink_cnt_r <= '0;
            blink       <= 1'b1;
        end else begin
            mode_r      <= mode_next_s;
            blink_cnt_r <= blink_cnt_next_s;
            blink       <= blink_next_s;
            case (mode_r)
                MODE_RUN: begin
                    if (sec_tick) begin
                        seconds <= inc_mod60(seconds);
                        if (seconds == SEC_MAX) begin
                            minutes <= inc_mod60(minutes);
                            if (minutes == MIN_MAX) begin
                                hours <= inc_mod24(hours);
                            end
                        end
                    end
                end
                MODE_SET_HR: begin
                    if (!btn_mode && btn_inc) begin
                        hours <= inc_mod24(hours);
                    end
                end
                MODE_SET_MIN: begin
                    if (btn_mode) begin
                        seconds <= 6'd0;
                    end else if (btn_inc) begin
                        minutes <= inc_mod60(minutes);
                    end
                end
                default: begin
                    hours <= hours;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with four clock cycles per second.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       sec_tick;
    logic       blink;

    int n_checks = 0;
    int n_fail   = 0;

    clock_set_ctrl #(.TICKS_PER_SEC(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .mode     (mode),
        .sec_tick (sec_tick),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({hours, minutes, seconds, mode, sec_tick, blink} !== {5'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: got h=%0d m=%0d s=%0d mode=%0d tick=%0b blink=%0b, want 0 0 0 0 0 1",
                     hours, minutes, seconds, mode, sec_tick, blink);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_run();
        for (int i = 1; i <= 13; i++) begin
            if (i <= 12) begin
                n_checks++;
                if (sec_tick !== ((i % 4) == 0)) begin
                    n_fail++;
                    $display("FAIL run_tick cycle %0d: got %0b, want %0b", i, sec_tick, ((i % 4) == 0));
                end
            end
            n_checks++;
            if (seconds !== 6'((i - 1) / 4)) begin
                n_fail++;
                $display("FAIL run_seconds cycle %0d: got %0d, want %0d", i, seconds, (i - 1) / 4);
            end
            if (i < 13) step();
        end
    endtask

    task automatic test_set_time();
        pulse_mode();
        n_checks++;
        if (mode !== 2'd1) begin
            n_fail++;
            $display("FAIL set_enter_hr: got mode %0d, want 1", mode);
        end
        btn_inc = 1'b1;
        repeat (25) step();
        btn_inc = 1'b0;
        n_checks++;
        if ({hours, minutes, seconds} !== {5'd1, 6'd0, 6'd3}) begin
            n_fail++;
            $display("FAIL set_hours_25: got %0d:%0d:%0d, want 1:0:3", hours, minutes, seconds);
        end
        pulse_mode();
        n_checks++;
        if (mode !== 2'd2) begin
            n_fail++;
            $display("FAIL set_enter_min: got mode %0d, want 2", mode);
        end
        btn_inc = 1'b1;
        for (int i = 0; i < 61; i++) begin
            step();
            n_checks++;
            if (hours !== 5'd1) begin
                n_fail++;
                $display("FAIL set_min_hours_hold inc %0d: got hours %0d, want 1", i, hours);
            end
        end
        btn_inc = 1'b0;
        n_checks++;
        if ({minutes, seconds} !== {6'd1, 6'd3}) begin
            n_fail++;
            $display("FAIL set_minutes_61: got m=%0d s=%0d, want m=1 s=3", minutes, seconds);
        end
        pulse_mode();
        n_checks++;
        if ({hours, minutes, seconds, mode} !== {5'd1, 6'd1, 6'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL set_return_run: got %0d:%0d:%0d mode %0d, want 1:1:0 mode 0",
                     hours, minutes, seconds, mode);
        end
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (sec_tick !== (k == 4)) begin
                n_fail++;
                $display("FAIL first_tick cycle %0d: got %0b, want %0b", k, sec_tick, (k == 4));
            end
            step();
        end
        n_checks++;
        if (seconds !== 6'd1) begin
            n_fail++;
            $display("FAIL first_tick_seconds: got %0d, want 1", seconds);
        end
    endtask

    task automatic test_same_cycle();
        pulse_mode();
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        n_checks++;
        if ({mode, hours} !== {2'd2, 5'd1}) begin
            n_fail++;
            $display("FAIL mode_inc_same_cycle: got mode %0d hours %0d, want mode 2 hours 1", mode, hours);
        end
        pulse_mode();
        n_checks++;
        if ({mode, minutes, seconds} !== {2'd0, 6'd1, 6'd0}) begin
            n_fail++;
            $display("FAIL same_cycle_back_run: got mode %0d m %0d s %0d, want 0 1 0", mode, minutes, seconds);
        end
    endtask

    task automatic test_blink();
        pulse_mode();
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (blink !== ((j % 4) < 2)) begin
                n_fail++;
                $display("FAIL blink_set_hr phase %0d: got %0b, want %0b", j, blink, ((j % 4) < 2));
            end
            step();
        end
        pulse_mode();
        pulse_mode();
        for (int j = 0; j < 6; j++) begin
            n_checks++;
            if (blink !== 1'b1) begin
                n_fail++;
                $display("FAIL blink_run cycle %0d: got %0b, want 1", j, blink);
            end
            step();
        end
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        while (!sec_tick && n < 10) begin
            step();
            n++;
        end
        n_checks++;
        if (sec_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: got sec_tick %0b, want 1 within 10 cycles", name, sec_tick);
        end
    endtask

    task automatic test_day_wrap();
        int n = 0;
        pulse_mode();
        btn_inc = 1'b1;
        repeat (22) step();
        btn_inc = 1'b0;
        pulse_mode();
        btn_inc = 1'b1;
        repeat (58) step();
        btn_inc = 1'b0;
        n_checks++;
        if ({hours, minutes} !== {5'd23, 6'd59}) begin
            n_fail++;
            $display("FAIL wrap_setup: got %0d:%0d, want 23:59", hours, minutes);
        end
        pulse_mode();
        while (seconds != 6'd59 && n < 400) begin
            step();
            n++;
        end
        n_checks++;
        if (seconds !== 6'd59) begin
            n_fail++;
            $display("FAIL wrap_reach_59: got seconds %0d, want 59 within 400 cycles", seconds);
        end
        wait_tick("wrap_tick");
        n_checks++;
        if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd59}) begin
            n_fail++;
            $display("FAIL wrap_before: got %0d:%0d:%0d, want 23:59:59", hours, minutes, seconds);
        end
        step();
        n_checks++;
        if ({hours, minutes, seconds, mode} !== {5'd0, 6'd0, 6'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL wrap_after: got %0d:%0d:%0d mode %0d, want 0:0:0 mode 0",
                     hours, minutes, seconds, mode);
        end
    endtask

    task automatic test_mode_on_tick();
        wait_tick("coincide_tick");
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        n_checks++;
        if ({seconds, mode} !== {6'd1, 2'd1}) begin
            n_fail++;
            $display("FAIL mode_on_tick: got s=%0d mode=%0d, want s=1 mode=1", seconds, mode);
        end
    endtask

    task automatic test_async_reset();
        pulse_mode();
        btn_inc = 1'b1;
        repeat (3) step();
        btn_inc = 1'b0;
        n_checks++;
        if ({mode, minutes} !== {2'd2, 6'd3}) begin
            n_fail++;
            $display("FAIL pre_reset_state: got mode %0d m %0d, want mode 2 m 3", mode, minutes);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({hours, minutes, seconds, mode, sec_tick, blink} !== {5'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: got h=%0d m=%0d s=%0d mode=%0d tick=%0b blink=%0b, want 0 0 0 0 0 1",
                     hours, minutes, seconds, mode, sec_tick, blink);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (sec_tick !== (k == 4)) begin
                n_fail++;
                $display("FAIL post_reset_tick cycle %0d: got %0b, want %0b", k, sec_tick, (k == 4));
            end
            step();
        end
        n_checks++;
        if ({hours, minutes, seconds, mode} !== {5'd0, 6'd0, 6'd1, 2'd0}) begin
            n_fail++;
            $display("FAIL post_reset_count: got %0d:%0d:%0d mode %0d, want 0:0:1 mode 0",
                     hours, minutes, seconds, mode);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_set_time();
        test_same_cycle();
        test_blink();
        test_day_wrap();
        test_mode_on_tick();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
